ram_port_arbiter: RTL and testbench

//   Shares one single-ported RAM between instruction fetch (IF) and the

---
 rtl/ram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and the MEMORY stage.
// Each access runs IDLE -> ISSUE -> WAIT -> ACK against a fixed RAM read latency.
module ram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned RAM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_stall,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_ack,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_stall,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int unsigned WAIT_W   = (RAM_LATENCY  < 2) ? 1 : $clog2(RAM_LATENCY + 1);
   localparam int unsigned STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t                state, next_state;
   logic                  grant_mem, grant_mem_d;
   logic                  is_store, is_store_d;
   logic [WAIT_W-1:0]     wait_cnt, wait_cnt_d;
   logic [STARVE_W-1:0]   starve_cnt, starve_cnt_d;
   logic                  if_ack_d, mem_ack_d, ram_en_d, ram_we_d;
   logic [DATA_WIDTH-1:0] if_rdata_d, mem_rdata_d, ram_wdata_d;
   logic [ADDR_WIDTH-1:0] ram_addr_d;
   logic                  any_req, pick_if, starved, last_wait;

   assign any_req   = if_req | mem_req;
   assign starved   = (starve_cnt == STARVE_W'(STARVE_LIMIT));
   assign pick_if   = if_req & (~mem_req | starved);
   assign last_wait = (wait_cnt == WAIT_W'(1));

   assign if_stall  = if_req & ~if_ack;
   assign mem_stall = mem_req & ~mem_ack;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req)   next_state = ISSUE;
         ISSUE:                  next_state = WAIT;
         WAIT:    if (last_wait) next_state = ACK;
         ACK:                    next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // Next values of all registered outputs and bookkeeping
   always_comb begin
      grant_mem_d  = grant_mem;
      is_store_d   = is_store;
      wait_cnt_d   = wait_cnt;
      starve_cnt_d = starve_cnt;
      if_rdata_d   = if_rdata;
      mem_rdata_d  = mem_rdata;
      ram_we_d     = ram_we;
      ram_addr_d   = ram_addr;
      ram_wdata_d  = ram_wdata;
      ram_en_d     = 1'b0;
      if_ack_d     = 1'b0;
      mem_ack_d    = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               ram_en_d    = 1'b1;
               grant_mem_d = ~pick_if;
               if (pick_if) begin
                  ram_we_d     = 1'b0;
                  is_store_d   = 1'b0;
                  ram_addr_d   = if_addr;
                  ram_wdata_d  = '0;
                  starve_cnt_d = '0;
               end else begin
                  ram_we_d    = mem_we;
                  is_store_d  = mem_we;
                  ram_addr_d  = mem_addr;
                  ram_wdata_d = mem_wdata;
                  // Count MEM wins that kept a waiting fetch out, saturating
                  if (!if_req)       starve_cnt_d = '0;
                  else if (!starved) starve_cnt_d = starve_cnt + STARVE_W'(1);
               end
            end
         end
         ISSUE: begin
            ram_we_d   = 1'b0;
            wait_cnt_d = WAIT_W'(RAM_LATENCY);
         end
         WAIT: begin
            if (last_wait) begin
               if (grant_mem) begin
                  mem_ack_d = 1'b1;
                  if (!is_store) mem_rdata_d = ram_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = ram_rdata;
               end
            end else begin
               wait_cnt_d = wait_cnt - WAIT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Output and bookkeeping registers
   always_ff @(posedge clock) begin
      if (reset) begin
         grant_mem  <= 1'b0;
         is_store   <= 1'b0;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         if_ack     <= 1'b0;
         mem_ack    <= 1'b0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         grant_mem  <= grant_mem_d;
         is_store   <= is_store_d;
         wait_cnt   <= wait_cnt_d;
         starve_cnt <= starve_cnt_d;
         if_ack     <= if_ack_d;
         mem_ack    <= mem_ack_d;
         if_rdata   <= if_rdata_d;
         mem_rdata  <= mem_rdata_d;
         ram_en     <= ram_en_d;
         ram_we     <= ram_we_d;
         ram_addr   <= ram_addr_d;
         ram_wdata  <= ram_wdata_d;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one latency-1 instance with a 1-cycle RAM model
// and one latency-3 instance with a 3-stage RAM model.
module tb_ram_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;

   // Latency-1 instance
   logic        if_req0, if_ack0, if_stall0, mem_req0, mem_we0, mem_ack0, mem_stall0;
   logic        ram_en0, ram_we0;
   logic [31:0] if_addr0, if_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
   logic [31:0] ram_addr0, ram_wdata0, ram_rdata0;
   logic [31:0] ram0 [0:63];

   // Latency-3 instance
   logic        if_req1, if_ack1, if_stall1, mem_req1, mem_we1, mem_ack1, mem_stall1;
   logic        ram_en1, ram_we1;
   logic [31:0] if_addr1, if_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [31:0] ram_addr1, ram_wdata1, ram_rdata1, pipe1_a, pipe1_b;
   logic [31:0] ram1 [0:63];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(1), .STARVE_LIMIT(4)) u0 (
      .clock(clock), .reset(reset),
      .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_rdata(if_rdata0), .if_stall(if_stall0),
      .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_ack(mem_ack0), .mem_rdata(mem_rdata0), .mem_stall(mem_stall0),
      .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
      .ram_rdata(ram_rdata0));

   ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(3), .STARVE_LIMIT(4)) u1 (
      .clock(clock), .reset(reset),
      .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1), .if_stall(if_stall1),
      .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_ack(mem_ack1), .mem_rdata(mem_rdata1), .mem_stall(mem_stall1),
      .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
      .ram_rdata(ram_rdata1));

   // RAM with one edge of read latency
   always @(posedge clock) begin
      if (ram_en0) begin
         if (ram_we0) ram0[ram_addr0[7:2]] <= ram_wdata0;
         ram_rdata0 <= ram0[ram_addr0[7:2]];
      end
   end

   // RAM with three edges of read latency
   always @(posedge clock) begin
      if (reset) begin
         pipe1_a    <= '0;
         pipe1_b    <= '0;
         ram_rdata1 <= '0;
      end else begin
         if (ram_en1) begin
            if (ram_we1) ram1[ram_addr1[7:2]] <= ram_wdata1;
            pipe1_a <= ram1[ram_addr1[7:2]];
         end
         pipe1_b    <= pipe1_a;
         ram_rdata1 <= pipe1_b;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram0[i] = 32'h0;
         ram1[i] = 32'h0;
      end
      ram0[2] = 32'h8C12_0008;
      ram0[4] = 32'h1234_5678;
      ram1[5] = 32'hCAFE_F00D;

      reset = 1'b1;
      if_req0 = 0; if_addr0 = 0; mem_req0 = 0; mem_we0 = 0; mem_addr0 = 0; mem_wdata0 = 0;
      if_req1 = 0; if_addr1 = 0; mem_req1 = 0; mem_we1 = 0; mem_addr1 = 0; mem_wdata1 = 0;

      // 1: reset state
      tick(); tick(); tick();
      check("rst_acks",   {30'd0, if_ack0, mem_ack0}, 32'd0);
      check("rst_ram",    {30'd0, ram_en0, ram_we0}, 32'd0);
      check("rst_addr",   ram_addr0, 32'd0);
      check("rst_wdata",  ram_wdata0, 32'd0);
      check("rst_rdata",  if_rdata0 | mem_rdata0, 32'd0);
      check("rst_stalls", {30'd0, if_stall0, mem_stall0}, 32'd0);
      check("rst_state",  32'(u0.state), 32'd0);
      reset = 1'b0;
      tick();

      // 2: single fetch
      if_req0 = 1; if_addr0 = 32'h8;
      tick();
      check("f_en",    {31'd0, ram_en0}, 32'd1);
      check("f_addr",  ram_addr0, 32'h8);
      check("f_we",    {31'd0, ram_we0}, 32'd0);
      check("f_stall", {31'd0, if_stall0}, 32'd1);
      tick();
      check("f_en_off", {30'd0, ram_en0, if_ack0}, 32'd0);
      tick();
      check("f_ack",      {31'd0, if_ack0}, 32'd1);
      check("f_rdata",    if_rdata0, 32'h8C12_0008);
      check("f_stall_lo", {31'd0, if_stall0}, 32'd0);
      if_req0 = 0;
      tick();
      check("f_ack_pulse", {31'd0, if_ack0}, 32'd0);

      // 3: store then load
      mem_req0 = 1; mem_we0 = 1; mem_addr0 = 32'hC; mem_wdata0 = 32'h2A;
      tick();
      check("sw_en_we", {30'd0, ram_en0, ram_we0}, 32'd3);
      check("sw_addr",  ram_addr0, 32'hC);
      check("sw_wdata", ram_wdata0, 32'h2A);
      tick();
      check("sw_we_off", {30'd0, ram_en0, ram_we0}, 32'd0);
      tick();
      check("sw_ack",   {31'd0, mem_ack0}, 32'd1);
      check("sw_rdata", mem_rdata0, 32'd0);
      mem_we0 = 0;
      tick();
      check("ack_idle", {31'd0, mem_ack0}, 32'd0);
      tick();
      check("lw_en_we", {30'd0, ram_en0, ram_we0}, 32'd2);
      check("lw_addr",  ram_addr0, 32'hC);
      tick(); tick();
      check("lw_ack",    {31'd0, mem_ack0}, 32'd1);
      check("lw_rdata",  mem_rdata0, 32'h2A);
      check("lw_if_hold", if_rdata0, 32'h8C12_0008);
      mem_req0 = 0;
      tick();

      // 4: both requesting; fetch wins after four MEM grants
      if_req0 = 1; if_addr0 = 32'h8; mem_req0 = 1; mem_we0 = 0; mem_addr0 = 32'hC;
      for (int g = 0; g < 6; g++) begin
         logic exp_if;
         exp_if = (g == 4);
         tick();
         check("arb_addr", ram_addr0, exp_if ? 32'h8 : 32'hC);
         tick(); tick();
         check("arb_if_ack",   {31'd0, if_ack0},   {31'd0, exp_if});
         check("arb_mem_ack",  {31'd0, mem_ack0},  {31'd0, ~exp_if});
         check("arb_if_stall", {31'd0, if_stall0}, {31'd0, ~exp_if});
         tick();
      end
      if_req0 = 0; mem_req0 = 0;
      tick();

      // 5: reset during WAIT of a fetch
      if_req0 = 1; if_addr0 = 32'h10;
      tick(); tick();
      reset = 1'b1;
      tick();
      check("rw_ack",   {30'd0, if_ack0, ram_en0}, 32'd0);
      check("rw_rdata", if_rdata0 | mem_rdata0, 32'd0);
      reset = 1'b0;
      tick();
      check("rw_reissue", {31'd0, ram_en0}, 32'd1);
      check("rw_addr",    ram_addr0, 32'h10);
      tick(); tick();
      check("rw_ack2",  {31'd0, if_ack0}, 32'd1);
      check("rw_data2", if_rdata0, 32'h1234_5678);
      if_req0 = 0;
      tick();

      // 6: latency-3 load, ack after five edges
      mem_req1 = 1; mem_we1 = 0; mem_addr1 = 32'h14;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("l3_ack",   {31'd0, mem_ack1}, (k == 5) ? 32'd1 : 32'd0);
         check("l3_rdata", mem_rdata1, (k == 5) ? 32'hCAFE_F00D : 32'd0);
      end
      mem_req1 = 0;
      tick();
      check("l3_ack_off", {31'd0, mem_ack1}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
